// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared types and widths for the icache/dcache line arbiter
package cache_arb_pkg;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RECOVER} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - serialises icache/dcache line transactions onto one adaptor port
// ARB_RR_EN: round-robin tie breaking; otherwise dcache always wins ties.
module cache_arbiter
  import cache_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t state, next_state;
  logic       i_req, d_req, d_wins_tie;
  logic       grant_i, grant_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef ARB_RR_EN
  owner_t last_grant;

  assign d_wins_tie = (last_grant == OWN_I);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= OWN_I;
    end else if (grant_d) begin
      last_grant <= OWN_D;
    end else if (grant_i) begin
      last_grant <= OWN_I;
    end
  end
`else
  assign d_wins_tie = 1'b1;
`endif

  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!i_req || d_wins_tie)) begin
          grant_d    = 1'b1;
          next_state = D_BUSY;
        end else if (i_req) begin
          grant_i    = 1'b1;
          next_state = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp) next_state = RECOVER;
      end
      RECOVER: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request outputs are registered and only change on a grant or on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      state <= next_state;
      if (grant_d) begin
        mem_address <= d_address;
        mem_write   <= d_write;
        mem_read    <= ~d_write;
        if (d_write) mem_wdata <= d_wdata;
      end else if (grant_i) begin
        mem_address <= i_address;
        mem_read    <= 1'b1;
        mem_write   <= 1'b0;
      end else if ((state == I_BUSY || state == D_BUSY) && mem_resp) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
    end
  end

  assign i_resp  = mem_resp & (state == I_BUSY);
  assign d_resp  = mem_resp & (state == D_BUSY);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed vector bench for cache_arbiter
module tb_cache_arbiter;
  import cache_arb_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read, d_read, d_write, i_resp, d_resp, mem_read, mem_write, mem_resp;
  logic [31:0]  i_address, d_address, mem_address;
  logic [255:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;

  int passed = 0;
  int total  = 0;
  logic last_d;  // model of the last owner, 1 = dcache

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         i_rd;
    logic         d_rd;
    logic         d_wr;
    logic [31:0]  i_addr;
    logic [31:0]  d_addr;
    logic [255:0] wdata;
    logic [255:0] rdata;
    int           lat;
    logic         exp_d;
    logic         exp_wr;
    logic [31:0]  exp_addr;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%b required=%b", name, act, exp);
    else passed++;
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else passed++;
  endtask

  task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else passed++;
  endtask

  task automatic drop_reqs();
    i_read  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  // Called one cycle after the grant edge; returns in RECOVER with mem_resp low.
  task automatic serve(input logic exp_d, input logic [31:0] exp_addr, input logic exp_wr,
                       input logic [255:0] exp_wdata, input logic [255:0] rdata, input int lat);
    chk1("mem_read", mem_read, ~exp_wr);
    chk1("mem_write", mem_write, exp_wr);
    chk32("mem_address", mem_address, exp_addr);
    if (exp_wr) chk256("mem_wdata", mem_wdata, exp_wdata);
    for (int k = 0; k < lat; k++) begin
      step();
      chk32("hold_address", mem_address, exp_addr);
      if (exp_wr) chk256("hold_wdata", mem_wdata, exp_wdata);
    end
    mem_resp  = 1'b1;
    mem_rdata = rdata;
    #1;
    chk1("i_resp", i_resp, ~exp_d);
    chk1("d_resp", d_resp, exp_d);
    chk256("rdata", exp_d ? d_rdata : i_rdata, rdata);
    step();
    mem_resp  = 1'b0;
    mem_rdata = '0;
    #1;
    chk1("recover_state", dut.state == RECOVER, 1'b1);
    chk1("recover_read", mem_read, 1'b0);
    chk1("recover_write", mem_write, 1'b0);
    chk1("recover_resp", i_resp | d_resp, 1'b0);
  endtask

  function automatic logic tie_d_wins();
`ifdef ARB_RR_EN
    return ~last_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    drop_reqs();
    mem_resp = 1'b0;
    step();
    rst    = 1'b0;
    last_d = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0, '0, {32{8'hA5}}, 3, 1'b0, 1'b0, 32'h0000_1000};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_2040, {8{32'h1234_5678}}, '0, 4, 1'b1, 1'b1, 32'h0000_2040};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_3000, '0, {32{8'h5A}}, 1, 1'b1, 1'b0, 32'h0000_3000};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_4080, {8{32'hCAFE_F00D}}, '0, 2, 1'b1, 1'b1, 32'h0000_4080};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_50C0, 32'h0, '0, {16{16'h3C96}}, 0, 1'b0, 1'b0, 32'h0000_50C0};

    i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
    do_reset();
    step();
    chk1("rst_state", dut.state == IDLE, 1'b1);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk32("rst_mem_address", mem_address, 32'h0);
    chk256("rst_mem_wdata", mem_wdata, '0);
    mem_resp = 1'b1;
    #1;
    chk1("idle_stray_resp", i_resp | d_resp, 1'b0);
    mem_resp = 1'b0;

    for (int v = 0; v < 5; v++) begin
      i_read = vecs[v].i_rd; d_read = vecs[v].d_rd; d_write = vecs[v].d_wr;
      i_address = vecs[v].i_addr; d_address = vecs[v].d_addr; d_wdata = vecs[v].wdata;
      step();
      serve(vecs[v].exp_d, vecs[v].exp_addr, vecs[v].exp_wr, vecs[v].wdata, vecs[v].rdata, vecs[v].lat);
      drop_reqs();
      step();
    end

    // Tie after reset: winner first, loser granted in first IDLE after RECOVER.
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_5000;
    d_read = 1'b1; d_address = 32'h0000_6000;
    step();
    serve(1'b1, 32'h0000_6000, 1'b0, '0, {32{8'h77}}, 1);
    d_read = 1'b0;
    step();
    chk1("turnaround_idle_read", mem_read, 1'b0);
    chk1("turnaround_state", dut.state == IDLE, 1'b1);
    step();
    serve(1'b0, 32'h0000_5000, 1'b0, '0, {32{8'h88}}, 1);
    drop_reqs();
    step();

    // Three successive isolated ties from reset.
    do_reset();
    for (int t = 0; t < 3; t++) begin
      logic wd;
      wd = tie_d_wins();
      i_read = 1'b1; i_address = 32'h0001_0000 + 32'(t * 64);
      d_read = 1'b1; d_address = 32'h0002_0000 + 32'(t * 64);
      step();
      serve(wd, wd ? d_address : i_address, 1'b0, '0, {32{8'(t + 1)}}, 1);
      last_d = wd;
      drop_reqs();
      step();
    end

    // Reset mid-burst abandons the dcache transaction.
    d_read = 1'b1; d_address = 32'h0000_7000;
    step();
    chk1("pre_rst_read", mem_read, 1'b1);
    step();
    rst = 1'b1;
    d_read = 1'b0;
    step();
    rst = 1'b0;
    chk1("midrst_read", mem_read, 1'b0);
    chk1("midrst_write", mem_write, 1'b0);
    chk32("midrst_address", mem_address, 32'h0);
    chk1("midrst_state", dut.state == IDLE, 1'b1);
    mem_resp = 1'b1;
    #1;
    chk1("midrst_stray_dresp", d_resp, 1'b0);
    chk1("midrst_stray_iresp", i_resp, 1'b0);
    step();
    mem_resp = 1'b0;
    chk1("midrst_no_regrant", mem_read | mem_write, 1'b0);

    // icache request rises during D_BUSY and changes address while waiting.
    d_write = 1'b1; d_address = 32'h0000_8000; d_wdata = {4{64'hDEAD_BEEF_0BAD_F00D}};
    step();
    i_read = 1'b1; i_address = 32'h0000_9000;
    serve(1'b1, 32'h0000_8000, 1'b1, {4{64'hDEAD_BEEF_0BAD_F00D}}, '0, 2);
    d_write = 1'b0;
    i_address = 32'h0000_9100;
    step();
    i_address = 32'h0000_9140;
    step();
    serve(1'b0, 32'h0000_9140, 1'b0, '0, {32{8'hE1}}, 1);
    drop_reqs();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-client arbiter feeding a single cacheline adaptor from the instruction cache (read-only) and the data cache (read/write). It sits between the split L1 caches and the adaptor and serialises full 256-bit line transactions so that only one client owns the memory port at a time. The arbiter is non-pipelined: one outstanding line transaction, registered request outputs, and combinational response steering back to the owning client.

## Interface
- No parameters; line width 256, address width 32 (package constants).
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_read  in  1  icache line read request, held until i_resp
- i_address  in  32  icache line address
- i_rdata  out  256  line returned to icache, valid while i_resp=1
- i_resp  out  1  one-cycle completion pulse to icache
- d_read  in  1  dcache line read request, held until d_resp
- d_write  in  1  dcache line write request, held until d_resp
- d_address  in  32  dcache line address
- d_wdata  in  256  dcache line to write
- d_rdata  out  256  line returned to dcache, valid while d_resp=1
- d_resp  out  1  one-cycle completion pulse to dcache
- mem_read  out  1  read request to adaptor, level, registered
- mem_write  out  1  write request to adaptor, level, registered
- mem_address  out  32  registered address of granted request
- mem_wdata  out  256  registered write line of granted request
- mem_rdata  in  256  line from adaptor, valid while mem_resp=1
- mem_resp  in  1  one-cycle completion pulse from adaptor

## Operation
- States: IDLE, I_BUSY, D_BUSY, RECOVER.
- IDLE: sample requests; on a grant, capture address (and d_wdata for writes) into output registers, assert mem_read or mem_write, go to owner's BUSY state. No request: stay.
- Tie (icache and dcache both requesting in IDLE): dcache wins (see Configuration).
- d_read and d_write both high is illegal; d_write takes precedence.
- I_BUSY/D_BUSY: hold mem_read/mem_write, mem_address, mem_wdata stable; ignore new client requests; on mem_resp=1 drop mem_read/mem_write at the next edge and go to RECOVER.
- RECOVER: one cycle, all mem requests low, then IDLE. Guarantees the adaptor finishes its cleanup cycle before the next request.
- Response steering: i_resp = mem_resp & (state==I_BUSY); d_resp = mem_resp & (state==D_BUSY). i_rdata and d_rdata both driven from mem_rdata (only meaningful with the matching resp).
- mem_resp outside BUSY states is ignored; no client resp generated.
- Reset (any state, incl. mid-transaction): state=IDLE; mem_read=0, mem_write=0, mem_address=0, mem_wdata=0; i_resp=d_resp=0 follow from state; last-grant register = icache. Partially completed adaptor burst is abandoned.

## Timing
- Request high in IDLE during cycle N -> mem_read/mem_write high from cycle N+1.
- mem_resp high in cycle M -> client resp high in same cycle M (combinational); mem request low from M+1; M+1 is RECOVER; earliest next grant sampled in M+2, issued M+3.
- Minimum turnaround between back-to-back transactions: 2 idle cycles of mem request.
- Client request that rises while another client is BUSY waits; it is granted in the first IDLE cycle after RECOVER.

## Configuration
- ARB_RR_EN defined: round-robin on ties; a one-bit last-grant register records the last owner and the other client wins the next tie. Reset value = icache, so the first tie goes to dcache.
- ARB_RR_EN undefined: fixed priority, dcache always wins ties; last-grant register not instantiated.
- Non-tie behaviour identical in both builds.

## Structure
- Shared package cache_arb_pkg: arb_state_t enum (IDLE, I_BUSY, D_BUSY, RECOVER), LINE_W=256, ADDR_W=32, owner_t enum (OWN_I, OWN_D).
- Single module; no sub-module needed. Grant selection is a small combinational block inside cache_arbiter.

## Test plan
- icache read 0x0000_1000 alone, adaptor returns line 0xA5..A5 -> mem_read from next cycle with mem_address 0x0000_1000; i_resp=1 with i_rdata=0xA5..A5; d_resp stays 0.
- dcache write 0x0000_2040 with d_wdata=0x1234..  -> mem_write=1, mem_wdata stable for whole burst; d_resp pulses once; mem_write=0 in following cycle and RECOVER observed.
- Both request in same cycle, fixed build -> dcache served first, icache granted in first IDLE after RECOVER. ARB_RR_EN build, three successive ties -> grants D, I, D.
- d_read and d_write both high -> treated as write (mem_write=1, mem_read=0).
- rst asserted in D_BUSY mid-burst -> next cycle mem_read=mem_write=0, state IDLE, no d_resp; stray mem_resp afterwards produces no client resp.
- icache request rising during D_BUSY, changing i_address while waiting -> granted address equals i_address sampled at grant cycle.
